// File: rtl/vector_operand_sequencer_if.sv
// Start/chunk handshake bundle between the operand sequencer and its producer/consumer.
// master drives the request side and chunk_ready; slave is the sequencer.
interface vector_operand_sequencer_if #(
  parameter int VLEN = 512,
  parameter int EV_W = 32
);
  localparam int NCH = VLEN / 64;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int VLW = $clog2(VLEN / 8) + 1;

  logic             start;
  logic             start_ready;
  logic [1:0]       sew;
  logic [VLW-1:0]   vl;
  logic [EV_W-1:0]  execution_vector_i;
  logic [VLEN-1:0]  vs2_reg;
  logic [VLEN-1:0]  vs1_reg;
  logic [VLEN-1:0]  v0_reg;

  logic             chunk_valid;
  logic             chunk_ready;
  logic [EV_W-1:0]  execution_vector;
  logic [63:0]      vs2;
  logic [63:0]      vs1;
  logic [63:0]      v0;
  logic [7:0]       body_mask;
  logic [KW-1:0]    chunk_index;
  logic             last;
  logic             done;

  modport master (
    output start, sew, vl, execution_vector_i, vs2_reg, vs1_reg, v0_reg, chunk_ready,
    input  start_ready, chunk_valid, execution_vector, vs2, vs1, v0, body_mask,
           chunk_index, last, done
  );

  modport slave (
    input  start, sew, vl, execution_vector_i, vs2_reg, vs1_reg, v0_reg, chunk_ready,
    output start_ready, chunk_valid, execution_vector, vs2, vs1, v0, body_mask,
           chunk_index, last, done
  );
endinterface

// File: rtl/vector_operand_sequencer.sv
// Latches vs2/vs1/v0 on start and issues them as 64-bit chunks with LSB-aligned mask bits
// and a per-chunk body mask. State | meaning: IDLE | accept start; ISSUE | chunk valid; FIN | done pulse.
module vector_operand_sequencer #(
  parameter int VLEN = 512,
  parameter int EV_W = 32
) (
  input logic                       clock,
  input logic                       n_reset,
  vector_operand_sequencer_if.slave bus
);
  localparam int NCH = VLEN / 64;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int VLW = $clog2(VLEN / 8) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sew_q, sew_d;
  logic [VLW-1:0]  left_q, left_d;
  logic [KW-1:0]   k_q, k_d;
  logic [EV_W-1:0] ev_q, ev_d;
  logic [VLEN-1:0] vs2_rem_q, vs2_rem_d;
  logic [VLEN-1:0] vs1_rem_q, vs1_rem_d;
  logic [VLEN-1:0] v0_rem_q, v0_rem_d;
  logic [63:0]     vs2_out_q, vs2_out_d;
  logic [63:0]     vs1_out_q, vs1_out_d;
  logic [63:0]     v0_out_q, v0_out_d;
  logic [7:0]      bmask_q, bmask_d;
  logic            last_q, last_d;

  logic [VLW-1:0]  vlmax;
  logic [VLW-1:0]  vl_eff;
  logic [VLW-1:0]  left_step;

  function automatic logic [VLW-1:0] epc_of(input logic [1:0] s);
    logic [VLW-1:0] r;
    unique case (s)
      2'b00:   r = VLW'(8);
      2'b01:   r = VLW'(4);
      2'b10:   r = VLW'(2);
      default: r = VLW'(1);
    endcase
    return r;
  endfunction

  function automatic logic [VLW-1:0] vlmax_of(input logic [1:0] s);
    logic [VLW-1:0] r;
    unique case (s)
      2'b00:   r = VLW'(VLEN / 8);
      2'b01:   r = VLW'(VLEN / 16);
      2'b10:   r = VLW'(VLEN / 32);
      default: r = VLW'(VLEN / 64);
    endcase
    return r;
  endfunction

  function automatic logic [63:0] v0_low(input logic [7:0] v, input logic [1:0] s);
    logic [63:0] r;
    unique case (s)
      2'b00:   r = {56'b0, v[7:0]};
      2'b01:   r = {60'b0, v[3:0]};
      2'b10:   r = {62'b0, v[1:0]};
      default: r = {63'b0, v[0]};
    endcase
    return r;
  endfunction

  function automatic logic [VLEN-1:0] v0_shr(input logic [VLEN-1:0] v, input logic [1:0] s);
    logic [VLEN-1:0] r;
    unique case (s)
      2'b00:   r = v >> 8;
      2'b01:   r = v >> 4;
      2'b10:   r = v >> 2;
      default: r = v >> 1;
    endcase
    return r;
  endfunction

  // Slot i is live when it exists at this SEW and still lies below the remaining element count.
  function automatic logic [7:0] body_of(input logic [VLW-1:0] left, input logic [1:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = (i < int'(epc_of(s))) && (i < int'(left));
    end
    return b;
  endfunction

  assign vlmax     = vlmax_of(bus.sew);
  assign vl_eff    = (bus.vl > vlmax) ? vlmax : bus.vl;
  assign left_step = left_q - epc_of(sew_q);

  always_comb begin
    state_d   = state_q;
    sew_d     = sew_q;
    left_d    = left_q;
    k_d       = k_q;
    ev_d      = ev_q;
    vs2_rem_d = vs2_rem_q;
    vs1_rem_d = vs1_rem_q;
    v0_rem_d  = v0_rem_q;
    vs2_out_d = vs2_out_q;
    vs1_out_d = vs1_out_q;
    v0_out_d  = v0_out_q;
    bmask_d   = bmask_q;
    last_d    = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sew_d     = bus.sew;
          ev_d      = bus.execution_vector_i;
          left_d    = vl_eff;
          k_d       = '0;
          vs2_rem_d = bus.vs2_reg >> 64;
          vs1_rem_d = bus.vs1_reg >> 64;
          v0_rem_d  = v0_shr(bus.v0_reg, bus.sew);
          if (vl_eff == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_ISSUE;
            vs2_out_d = bus.vs2_reg[63:0];
            vs1_out_d = bus.vs1_reg[63:0];
            v0_out_d  = v0_low(bus.v0_reg[7:0], bus.sew);
            bmask_d   = body_of(vl_eff, bus.sew);
            last_d    = (vl_eff <= epc_of(bus.sew));
          end
        end
      end

      S_ISSUE: begin
        if (bus.chunk_ready) begin
          if (last_q) begin
            // Clear the chunk registers so IDLE/FIN present the same zeros as reset.
            state_d   = S_FIN;
            k_d       = '0;
            left_d    = '0;
            vs2_out_d = '0;
            vs1_out_d = '0;
            v0_out_d  = '0;
            bmask_d   = '0;
            last_d    = 1'b0;
          end else begin
            k_d       = k_q + KW'(1);
            left_d    = left_step;
            vs2_out_d = vs2_rem_q[63:0];
            vs1_out_d = vs1_rem_q[63:0];
            vs2_rem_d = vs2_rem_q >> 64;
            vs1_rem_d = vs1_rem_q >> 64;
            v0_out_d  = v0_low(v0_rem_q[7:0], sew_q);
            v0_rem_d  = v0_shr(v0_rem_q, sew_q);
            bmask_d   = body_of(left_step, sew_q);
            last_d    = (left_step <= epc_of(sew_q));
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      sew_q     <= '0;
      left_q    <= '0;
      k_q       <= '0;
      ev_q      <= '0;
      vs2_rem_q <= '0;
      vs1_rem_q <= '0;
      v0_rem_q  <= '0;
      vs2_out_q <= '0;
      vs1_out_q <= '0;
      v0_out_q  <= '0;
      bmask_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sew_q     <= sew_d;
      left_q    <= left_d;
      k_q       <= k_d;
      ev_q      <= ev_d;
      vs2_rem_q <= vs2_rem_d;
      vs1_rem_q <= vs1_rem_d;
      v0_rem_q  <= v0_rem_d;
      vs2_out_q <= vs2_out_d;
      vs1_out_q <= vs1_out_d;
      v0_out_q  <= v0_out_d;
      bmask_q   <= bmask_d;
      last_q    <= last_d;
    end
  end

  assign bus.start_ready      = (state_q == S_IDLE);
  assign bus.chunk_valid      = (state_q == S_ISSUE);
  assign bus.done             = (state_q == S_FIN);
  assign bus.execution_vector = ev_q;
  assign bus.vs2              = vs2_out_q;
  assign bus.vs1              = vs1_out_q;
  assign bus.v0               = v0_out_q;
  assign bus.body_mask        = bmask_q;
  assign bus.chunk_index      = k_q;
  assign bus.last             = last_q;
endmodule

// File: tb/tb_vector_operand_sequencer.sv
// Directed bench for vector_operand_sequencer: one task per scenario, inline checks.
module tb_vector_operand_sequencer;
  localparam int VLEN = 512;
  localparam int EV_W = 32;

  logic clock = 1'b0;
  logic n_reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vector_operand_sequencer_if #(.VLEN(VLEN), .EV_W(EV_W)) bus ();

  vector_operand_sequencer #(.VLEN(VLEN), .EV_W(EV_W)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] pat2(input int k);
    return {32'hA2A2_0000 | 32'(k), 32'h5A5A_0000 | 32'(k)};
  endfunction

  function automatic logic [63:0] pat1(input int k);
    return {32'h1111_0000 | 32'(k), 32'hCAFE_0000 | 32'(k)};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load_regs(input logic [VLEN-1:0] v0);
    for (int k = 0; k < VLEN / 64; k++) begin
      bus.vs2_reg[64*k +: 64] = pat2(k);
      bus.vs1_reg[64*k +: 64] = pat1(k);
    end
    bus.v0_reg = v0;
  endtask

  // Accept happens in the cycle this is called (cycle 0); returns at cycle 1.
  task automatic start_op(input logic [1:0] sew, input logic [6:0] vl, input logic [31:0] ev);
    bus.sew = sew;
    bus.vl = vl;
    bus.execution_vector_i = ev;
    bus.start = 1'b1;
    checks++;
    if (bus.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_idle got=%b exp=1", bus.start_ready);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.chunk_ready = 1'b0;
    bus.sew = 2'b00;
    bus.vl = '0;
    bus.execution_vector_i = '0;
    bus.vs2_reg = '0;
    bus.vs1_reg = '0;
    bus.v0_reg = '0;
    #1 n_reset = 1'b0;
    #2;
    checks++;
    if ({bus.start_ready, bus.chunk_valid, bus.done, bus.last} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=1000",
               {bus.start_ready, bus.chunk_valid, bus.done, bus.last});
    end
    checks++;
    if ({bus.vs2, bus.vs1, bus.v0, bus.body_mask, bus.chunk_index, bus.execution_vector} !== '0) begin
      errors++;
      $display("FAIL reset_data got vs2=%h vs1=%h v0=%h bm=%h idx=%0d ev=%h exp=all zero",
               bus.vs2, bus.vs1, bus.v0, bus.body_mask, bus.chunk_index, bus.execution_vector);
    end
    @(posedge clock);
    #1 n_reset = 1'b1;
    tick();
    checks++;
    if ({bus.start_ready, bus.chunk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got=%b exp=10", {bus.start_ready, bus.chunk_valid});
    end
  endtask

  task automatic test_sew64;
    logic [7:0] a5 = 8'hA5;
    load_regs({{(VLEN-8){1'b1}}, 8'hA5});
    bus.chunk_ready = 1'b1;
    start_op(2'b11, 7'd8, 32'hDEAD_0064);
    // Scramble inputs and hold start: none of it may leak into the running operation.
    bus.vs2_reg = '0;
    bus.vs1_reg = '0;
    bus.v0_reg = '0;
    bus.sew = 2'b00;
    bus.vl = 7'd1;
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.done} !==
          {1'b1, (c == 8), 3'(c - 1), 8'h01, 1'b0}) begin
        errors++;
        $display("FAIL sew64_ctrl c=%0d got v=%b last=%b idx=%0d bm=%h done=%b exp v=1 last=%b idx=%0d bm=01 done=0",
                 c, bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.done, (c == 8), c - 1);
      end
      checks++;
      if (bus.v0 !== {63'b0, a5[c-1]}) begin
        errors++;
        $display("FAIL sew64_v0 c=%0d got=%h exp=%h", c, bus.v0, {63'b0, a5[c-1]});
      end
      checks++;
      if ({bus.vs2, bus.vs1, bus.execution_vector} !== {pat2(c - 1), pat1(c - 1), 32'hDEAD_0064}) begin
        errors++;
        $display("FAIL sew64_data c=%0d got vs2=%h vs1=%h ev=%h exp vs2=%h vs1=%h ev=dead0064",
                 c, bus.vs2, bus.vs1, bus.execution_vector, pat2(c - 1), pat1(c - 1));
      end
      tick();
    end
    checks++;
    if ({bus.done, bus.chunk_valid, bus.start_ready} !== 3'b100) begin
      errors++;
      $display("FAIL sew64_done got=%b exp=100", {bus.done, bus.chunk_valid, bus.start_ready});
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.chunk_valid, bus.start_ready} !== 3'b001) begin
      errors++;
      $display("FAIL sew64_idle got=%b exp=001", {bus.done, bus.chunk_valid, bus.start_ready});
    end
  endtask

  task automatic test_sew8;
    load_regs({{(VLEN-16){1'b1}}, 16'h3C5A});
    bus.chunk_ready = 1'b1;
    start_op(2'b00, 7'd13, 32'h0000_0813);
    checks++;
    if ({bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0} !==
        {1'b1, 1'b0, 3'd0, 8'hFF, 64'h5A}) begin
      errors++;
      $display("FAIL sew8_c0 got v=%b last=%b idx=%0d bm=%h v0=%h exp v=1 last=0 idx=0 bm=ff v0=5a",
               bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0);
    end
    checks++;
    if ({bus.vs2, bus.vs1} !== {pat2(0), pat1(0)}) begin
      errors++;
      $display("FAIL sew8_data0 got vs2=%h vs1=%h exp vs2=%h vs1=%h", bus.vs2, bus.vs1, pat2(0), pat1(0));
    end
    tick();
    checks++;
    if ({bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0} !==
        {1'b1, 1'b1, 3'd1, 8'h1F, 64'h3C}) begin
      errors++;
      $display("FAIL sew8_c1 got v=%b last=%b idx=%0d bm=%h v0=%h exp v=1 last=1 idx=1 bm=1f v0=3c",
               bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0);
    end
    checks++;
    if ({bus.vs2, bus.vs1} !== {pat2(1), pat1(1)}) begin
      errors++;
      $display("FAIL sew8_data1 got vs2=%h vs1=%h exp vs2=%h vs1=%h", bus.vs2, bus.vs1, pat2(1), pat1(1));
    end
    tick();
    checks++;
    if ({bus.done, bus.chunk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL sew8_done got=%b exp=10", {bus.done, bus.chunk_valid});
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [204:0] exp0, exp1, act;
    exp0 = {pat2(0), pat1(0), 64'h1, 8'h03, 3'd0, 1'b0, 1'b1};
    exp1 = {pat2(1), pat1(1), 64'h2, 8'h03, 3'd1, 1'b1, 1'b1};
    load_regs({{(VLEN-4){1'b0}}, 4'b1001});
    bus.chunk_ready = 1'b0;
    start_op(2'b10, 7'd4, 32'h0000_3204);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.chunk_ready = 1'b1;
      act = {bus.vs2, bus.vs1, bus.v0, bus.body_mask, bus.chunk_index, bus.last, bus.chunk_valid};
      checks++;
      if (act !== exp0) begin
        errors++;
        $display("FAIL bp_hold c=%0d got=%h exp=%h", c, act, exp0);
      end
      tick();
    end
    act = {bus.vs2, bus.vs1, bus.v0, bus.body_mask, bus.chunk_index, bus.last, bus.chunk_valid};
    checks++;
    if (act !== exp1) begin
      errors++;
      $display("FAIL bp_chunk1 got=%h exp=%h", act, exp1);
    end
    tick();
    checks++;
    if ({bus.done, bus.chunk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_done got=%b exp=10", {bus.done, bus.chunk_valid});
    end
    tick();
  endtask

  task automatic test_vl0;
    bus.chunk_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      start_op(2'(s), 7'd0, 32'h0000_0000 | 32'(s));
      checks++;
      if ({bus.done, bus.chunk_valid, bus.start_ready} !== 3'b100) begin
        errors++;
        $display("FAIL vl0_c1 sew=%0d got=%b exp=100", s, {bus.done, bus.chunk_valid, bus.start_ready});
      end
      tick();
      checks++;
      if ({bus.done, bus.chunk_valid, bus.start_ready} !== 3'b001) begin
        errors++;
        $display("FAIL vl0_c2 sew=%0d got=%b exp=001", s, {bus.done, bus.chunk_valid, bus.start_ready});
      end
    end
  endtask

  task automatic test_clamp;
    int count = 0;
    int done_cyc = 0;
    logic [7:0] last_bm = '0;
    logic [2:0] last_idx = '0;
    load_regs('0);
    bus.chunk_ready = 1'b1;
    start_op(2'b01, 7'd100, 32'h0000_1664);
    for (int c = 1; c <= 20; c++) begin
      if (bus.chunk_valid) begin
        count++;
        if (bus.last) begin
          last_bm = bus.body_mask;
          last_idx = bus.chunk_index;
        end
      end
      if (bus.done && done_cyc == 0) done_cyc = c;
      tick();
    end
    checks++;
    if (count != 8) begin
      errors++;
      $display("FAIL clamp_count got=%0d exp=8", count);
    end
    checks++;
    if ({last_bm, last_idx} !== {8'h0F, 3'd7}) begin
      errors++;
      $display("FAIL clamp_last got bm=%h idx=%0d exp bm=0f idx=7", last_bm, last_idx);
    end
    checks++;
    if (done_cyc != 9) begin
      errors++;
      $display("FAIL clamp_done_cycle got=%0d exp=9", done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_done = 1'b0;
    load_regs({VLEN{1'b1}});
    bus.chunk_ready = 1'b1;
    start_op(2'b10, 7'd8, 32'h0000_5208);
    tick();
    tick();
    checks++;
    if ({bus.chunk_valid, bus.chunk_index} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL rmid_at_k2 got v=%b idx=%0d exp v=1 idx=2", bus.chunk_valid, bus.chunk_index);
    end
    #1 n_reset = 1'b0;
    #1;
    checks++;
    if ({bus.start_ready, bus.chunk_valid, bus.done, bus.last} !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_ctrl got=%b exp=1000", {bus.start_ready, bus.chunk_valid, bus.done, bus.last});
    end
    checks++;
    if ({bus.vs2, bus.vs1, bus.v0, bus.body_mask, bus.chunk_index, bus.execution_vector} !== '0) begin
      errors++;
      $display("FAIL rmid_data got vs2=%h v0=%h bm=%h idx=%0d ev=%h exp=all zero",
               bus.vs2, bus.v0, bus.body_mask, bus.chunk_index, bus.execution_vector);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    n_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    checks++;
    if ({saw_done, bus.start_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_no_done got done_seen=%b start_ready=%b exp done_seen=0 start_ready=1",
               saw_done, bus.start_ready);
    end
    load_regs({{(VLEN-1){1'b0}}, 1'b1});
    start_op(2'b11, 7'd1, 32'h0000_BEEF);
    checks++;
    if ({bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0, bus.vs2, bus.execution_vector} !==
        {1'b1, 1'b1, 3'd0, 8'h01, 64'h1, pat2(0), 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL rmid_restart got v=%b last=%b idx=%0d bm=%h v0=%h vs2=%h ev=%h exp v=1 last=1 idx=0 bm=01 v0=1 vs2=%h ev=beef",
               bus.chunk_valid, bus.last, bus.chunk_index, bus.body_mask, bus.v0, bus.vs2,
               bus.execution_vector, pat2(0));
    end
    tick();
    checks++;
    if ({bus.done, bus.chunk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rmid_restart_done got=%b exp=10", {bus.done, bus.chunk_valid});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sew64();
    test_sew8();
    test_backpressure();
    test_vl0();
    test_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_operand_sequencer.md
# vector_operand_sequencer

Sequencing stage directly upstream of `vector_merge_unit`. It captures full-width source registers (vs2, vs1, v0) and the execution vector on a start handshake, then issues them as consecutive 64-bit chunks over a valid/ready interface. For each chunk it LSB-aligns the v0 mask bits for that chunk's elements, which is the layout the merge datapath consumes. It also supplies a per-chunk body mask so writeback can ignore tail elements at or beyond `vl`.

## Interface
- `VLEN`, 512: bits per vector register; must be a multiple of 64.
- `clock`  in  1  single clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation.
- `start_ready`  out  1  high when idle; a request is accepted when `start` and `start_ready` are both high.
- `sew`  in  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
- `vl`  in  $clog2(VLEN/8)+1  element count.
- `execution_vector_i`  in  execution_vector_t  operation descriptor; latched at start.
- `vs2_reg`, `vs1_reg`, `v0_reg`  in  VLEN each  full source registers; latched at start.
- `chunk_valid`  out  1  chunk outputs are valid.
- `chunk_ready`  in  1  downstream accepts the chunk.
- `execution_vector`  out  execution_vector_t  latched descriptor, held for the whole operation.
- `vs2`, `vs1`  out  64 each  source chunk k.
- `v0`  out  64  mask bits for chunk k in bits [epc-1:0]; all other bits 0.
- `body_mask`  out  8  bit i = 1 when element slot i of this chunk is below the effective `vl`.
- `chunk_index`  out  $clog2(VLEN/64)  index k of the current chunk.
- `last`  out  1  the current chunk is the final chunk.
- `done`  out  1  one-cycle pulse when the operation completes.

## Operation
- epc (elements per chunk) = 64/SEW, giving 8/4/2/1.
- vl_eff = min(vl, VLEN/SEW). Any larger `vl` is clamped to this value and never flagged.
- nchunks = ceil(vl_eff/epc).
- FSM states:
  - IDLE: `start_ready` = 1. On accept, latch `sew`, vl_eff, `execution_vector_i` and the three registers, and set k = 0. If vl_eff = 0, go to FIN; otherwise go to ISSUE.
  - ISSUE: `chunk_valid` = 1. On `chunk_valid & chunk_ready`: if k = nchunks-1, go to FIN; otherwise increment k.
  - FIN: `done` = 1 for one cycle, then go to IDLE.
- Chunk contents:
  - `vs2` = vs2_q[64k +: 64] and `vs1` = vs1_q[64k +: 64].
  - `v0`[epc-1:0] = v0_q[k·epc +: epc]; all higher bits are 0.
  - `body_mask`[i] = (i < epc) && (k·epc + i < vl_eff).
  - `last` = (k = nchunks-1).
- All chunk outputs are registered. They hold stable while `chunk_valid` is high and `chunk_ready` is low.
- Inputs `start`, `sew`, `vl` and the source registers are ignored outside the IDLE accept cycle.
- Changes to the source-register inputs after the accept cycle do not affect the chunks being issued.

## Timing
- Reset values: `start_ready` = 1; every other output, including `execution_vector`, is 0; FSM is in IDLE.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. The operation is abandoned and `done` does not pulse.
- Accept in cycle 0 produces `chunk_valid` with chunk 0 in cycle 1.
- With `chunk_ready` held high, throughput is one chunk per cycle. The last handshake occurs in cycle nchunks.
- `done` pulses in cycle nchunks+1. `start_ready` returns to 1 in cycle nchunks+2.
- When vl_eff = 0, `done` pulses in cycle 1 and `chunk_valid` is never asserted.
- Each chunk appears exactly once; no chunk is dropped or duplicated under any `chunk_ready` pattern.
- `start_ready` is low in ISSUE and FIN. A start raised in those states is not accepted.

## Test plan
- SEW=64, vl=8, `chunk_ready`=1 throughout, with v0_reg[7:0]=8'hA5:
  - 8 chunks are issued in cycles 1–8.
  - `v0` equals 1,0,1,0,0,1,0,1 for k = 0..7.
  - `body_mask`=8'h01 on every chunk; `last` is high only at k=7.
  - `done` pulses in cycle 9.
- SEW=8, vl=13, with v0_reg[15:0]=16'h3C5A:
  - Chunk 0: `v0`=8'h5A, `body_mask`=8'hFF.
  - Chunk 1: `v0`=8'h3C, `body_mask`=8'h1F, `last`=1.
  - `vs2`/`vs1` equal bits [63:0] and then [127:64] of the source registers.
- SEW=32, vl=4, `chunk_ready` held low in cycles 1–3:
  - Chunk 0 is held bit-stable through cycle 3 and is accepted in cycle 4.
  - Chunk 1 follows in cycle 5.
  - `done` pulses in cycle 6.
- vl=0 at any SEW: `done` pulses in cycle 1 and `chunk_valid` stays 0.
- SEW=16, vl=100 (VLEN=512):
  - vl is clamped to 32, giving 8 chunks.
  - The last chunk has `body_mask`=8'h0F.
- Reset pulse while at k=2 of a 4-chunk operation:
  - All outputs are 0, `start_ready`=1, and no `done` pulse occurs.
  - A new start after reset release issues its chunk 0 correctly.
